calc_control_fsm: RTL and testbench

Parametrised next-generation control unit for the N-bit keypad calculator. It sequences digit entry (shift-and-add by the datapath radix), operator and equals execution, and clear, all through a multi-cycle ALU start/done handshake. Compared with the existing single-cycle controller, it adds a digit-count limit, key back-pressure, and an ALU error state. It sits between the keypad decoder and the datapath registers/ALU muxes.

---
 rtl/calc_control_fsm.sv | 194 +++++++++++++++++++
 tb/tb_calc_control_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_control_fsm.sv
// Keypad calculator controller: sequences digit entry, operator/equals execution and
// clear through a multi-cycle ALU start/done handshake, with digit limit and error state.
module calc_control_fsm #(
    parameter int OP_W       = 2,
    parameter int OP_ADD     = 0,
    parameter int OP_MUL     = 2,
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_valid,
    input  logic [1:0]       key_type,
    output logic             key_ready,
    output logic             key_rej,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic             alu_err,
    output logic [1:0]       alu_mux_sig,
    output logic [OP_W-1:0]  op_input,
    output logic             op_mux_sig,
    output logic             display_mux_sig,
    output logic [3:0]       we,
    output logic [2:0]       clr,
    output logic [CNT_W-1:0] digit_count,
    output logic             err
);

    typedef enum logic [3:0] {
        IDLE, D_MUL, D_MUL_W, D_ADD, D_ADD_W, D_SHOW,
        O_EXEC, O_WAIT, O_SHOW, EQ, CLEAR, ERROR
    } state_t;

    localparam logic [1:0] KEY_DIGIT = 2'b00;
    localparam logic [1:0] KEY_EQ    = 2'b10;
    localparam logic [1:0] KEY_CLEAR = 2'b11;

    localparam logic [OP_W-1:0]  OP_MUL_V = OP_W'(OP_MUL);
    localparam logic [OP_W-1:0]  OP_ADD_V = OP_W'(OP_ADD);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);

    state_t     state, next_state;
    logic [1:0] last_key;
    logic       count_inc, count_clr;
    logic       count_full;

    assign key_ready  = (state == IDLE) || (state == ERROR);
    assign count_full = (digit_count >= MAX_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // last_key steers O_SHOW into EQ; digit_count only grows while below the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_key    <= 2'b00;
            digit_count <= '0;
        end else begin
            if (key_valid && key_ready) begin
                last_key <= key_type;
            end
            if (count_clr) begin
                digit_count <= '0;
            end else if (count_inc) begin
                digit_count <= digit_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state      = state;
        key_rej         = 1'b0;
        alu_start       = 1'b0;
        alu_mux_sig     = 2'b00;
        op_input        = '0;
        op_mux_sig      = 1'b0;
        display_mux_sig = 1'b0;
        we              = 4'b0000;
        clr             = 3'b000;
        err             = 1'b0;
        count_inc       = 1'b0;
        count_clr       = 1'b0;

        case (state)
            IDLE: begin
                if (key_valid) begin
                    case (key_type)
                        KEY_DIGIT: begin
                            if (!count_full) begin
                                next_state = D_MUL;
                                count_inc  = 1'b1;
                            end else begin
                                key_rej = 1'b1;
                            end
                        end
                        KEY_CLEAR: next_state = CLEAR;
                        default:   next_state = O_EXEC;
                    endcase
                end
            end
            D_MUL: begin
                alu_start   = 1'b1;
                alu_mux_sig = 2'b10;
                op_input    = OP_MUL_V;
                next_state  = D_MUL_W;
            end
            // Result is written on the same edge that done is seen
            D_MUL_W: begin
                alu_mux_sig = 2'b10;
                op_input    = OP_MUL_V;
                if (alu_done) begin
                    if (alu_err) begin
                        next_state = ERROR;
                    end else begin
                        we[0]      = 1'b1;
                        next_state = D_ADD;
                    end
                end
            end
            D_ADD: begin
                alu_start   = 1'b1;
                alu_mux_sig = 2'b01;
                op_input    = OP_ADD_V;
                next_state  = D_ADD_W;
            end
            D_ADD_W: begin
                alu_mux_sig = 2'b01;
                op_input    = OP_ADD_V;
                if (alu_done) begin
                    if (alu_err) begin
                        next_state = ERROR;
                    end else begin
                        we[0]      = 1'b1;
                        next_state = D_SHOW;
                    end
                end
            end
            D_SHOW: begin
                we[2]      = 1'b1;
                next_state = IDLE;
            end
            O_EXEC: begin
                alu_start  = 1'b1;
                op_mux_sig = 1'b1;
                next_state = O_WAIT;
            end
            O_WAIT: begin
                op_mux_sig = 1'b1;
                if (alu_done) begin
                    if (alu_err) begin
                        next_state = ERROR;
                    end else begin
                        we[1]      = 1'b1;
                        we[3]      = 1'b1;
                        next_state = O_SHOW;
                    end
                end
            end
            O_SHOW: begin
                display_mux_sig = 1'b1;
                we[2]           = 1'b1;
                clr[0]          = 1'b1;
                count_clr       = 1'b1;
                next_state      = (last_key == KEY_EQ) ? EQ : IDLE;
            end
            EQ: begin
                clr[1]     = 1'b1;
                next_state = IDLE;
            end
            CLEAR: begin
                clr        = 3'b111;
                count_clr  = 1'b1;
                next_state = IDLE;
            end
            ERROR: begin
                err = 1'b1;
                if (key_valid) begin
                    if (key_type == KEY_CLEAR) begin
                        next_state = CLEAR;
                    end else begin
                        key_rej = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc_control_fsm.sv
// Self-checking bench for calc_control_fsm: a key-level model expands each key into the
// cycle-by-cycle output timeline it must produce, which is replayed against the DUT.
module tb_calc_control_fsm;

    localparam int OP_W       = 2;
    localparam int OP_ADD     = 0;
    localparam int OP_MUL     = 2;
    localparam int MAX_DIGITS = 8;
    localparam int CNT_W      = 4;

    localparam logic [1:0] K_DIG = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_EQ  = 2'b10;
    localparam logic [1:0] K_CLR = 2'b11;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             key_valid = 1'b0;
    logic [1:0]       key_type = 2'b00;
    logic             alu_done = 1'b0;
    logic             alu_err = 1'b0;
    logic             key_ready, key_rej, alu_start, op_mux_sig, display_mux_sig, err;
    logic [1:0]       alu_mux_sig;
    logic [OP_W-1:0]  op_input;
    logic [3:0]       we;
    logic [2:0]       clr;
    logic [CNT_W-1:0] digit_count;
    logic [16:0]      out_vec;

    always #5 clk = ~clk;

    calc_control_fsm #(
        .OP_W(OP_W), .OP_ADD(OP_ADD), .OP_MUL(OP_MUL),
        .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .key_valid(key_valid), .key_type(key_type),
        .key_ready(key_ready), .key_rej(key_rej),
        .alu_start(alu_start), .alu_done(alu_done), .alu_err(alu_err),
        .alu_mux_sig(alu_mux_sig), .op_input(op_input), .op_mux_sig(op_mux_sig),
        .display_mux_sig(display_mux_sig), .we(we), .clr(clr),
        .digit_count(digit_count), .err(err)
    );

    assign out_vec = {key_ready, key_rej, alu_start, alu_mux_sig, op_input,
                      op_mux_sig, display_mux_sig, we, clr, err};

    typedef struct {
        logic             kv;
        logic [1:0]       kt;
        logic             done;
        logic             aerr;
        logic [16:0]      exp;
        logic [CNT_W-1:0] cnt;
    } cyc_t;

    cyc_t plan[$];
    int   model_count;
    bit   model_err;
    int   noise;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    cyc_t e;

    function automatic logic [16:0] ev(logic rdy, logic rej, logic st, logic [1:0] mux,
                                       logic [1:0] op, logic opm, logic disp,
                                       logic [3:0] w, logic [2:0] c, logic er);
        return {rdy, rej, st, mux, op, opm, disp, w, c, er};
    endfunction

    function automatic void push(logic kv, logic [1:0] kt, logic done, logic aerr, logic [16:0] x);
        cyc_t c;
        c.kv   = kv;
        c.kt   = kt;
        c.done = done;
        c.aerr = aerr;
        c.exp  = x;
        c.cnt  = CNT_W'(model_count);
        plan.push_back(c);
    endfunction

    // Stray key strobes presented while the controller is busy
    function automatic logic busy_kv();
        if (noise == 2) return 1'b1;
        if (noise == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    function automatic logic stray_done();
        return (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic void idle_cycles(int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 2'b00, stray_done(), 1'b0,
                 ev(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 3'b000, model_err));
    endfunction

    // One ALU operation lasting d cycles from start to done; returns 0 if it errored
    function automatic logic alu_phase(logic [1:0] mux, logic [1:0] op, logic opm,
                                       logic [3:0] wdone, int d, logic fail);
        push(busy_kv(), 2'($urandom_range(0, 3)), stray_done(), stray_done(),
             ev(1'b0, 1'b0, 1'b1, mux, op, opm, 1'b0, 4'b0000, 3'b000, 1'b0));
        for (int i = 1; i < d; i++)
            push(busy_kv(), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
                 ev(1'b0, 1'b0, 1'b0, mux, op, opm, 1'b0, 4'b0000, 3'b000, 1'b0));
        push(busy_kv(), 2'($urandom_range(0, 3)), 1'b1, fail,
             ev(1'b0, 1'b0, 1'b0, mux, op, opm, 1'b0, fail ? 4'b0000 : wdone, 3'b000, 1'b0));
        if (fail) model_err = 1'b1;
        return !fail;
    endfunction

    // estage: 0 no error, 1 first ALU op errors, 2 second ALU op (digits only) errors
    function automatic void plan_key(logic [1:0] kt, int dm, int da, int estage);
        logic rej;
        rej = model_err ? (kt != K_CLR) : (kt == K_DIG && model_count >= MAX_DIGITS);
        push(1'b1, kt, 1'b0, 1'b0,
             ev(1'b1, rej, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 3'b000, model_err));
        if (rej) return;
        if (kt == K_CLR) begin
            push(busy_kv(), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
                 ev(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 3'b111, 1'b0));
            model_count = 0;
            model_err   = 1'b0;
        end else if (kt == K_DIG) begin
            model_count++;
            if (!alu_phase(2'b10, 2'(OP_MUL), 1'b0, 4'b0001, dm, estage == 1)) return;
            if (!alu_phase(2'b01, 2'(OP_ADD), 1'b0, 4'b0001, da, estage == 2)) return;
            push(busy_kv(), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
                 ev(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0100, 3'b000, 1'b0));
        end else begin
            if (!alu_phase(2'b00, 2'b00, 1'b1, 4'b1010, dm, estage != 0)) return;
            push(busy_kv(), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
                 ev(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 4'b0100, 3'b001, 1'b0));
            model_count = 0;
            if (kt == K_EQ)
                push(busy_kv(), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
                     ev(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 3'b010, 1'b0));
        end
    endfunction

    task automatic drive(input cyc_t c);
        key_valid = c.kv;
        key_type  = c.kt;
        alu_done  = c.done;
        alu_err   = c.aerr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_vec !== ev(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0) ||
            digit_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_initial got %h/%0d want key_ready only/0", out_vec, digit_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_count = 0; model_err = 1'b0; noise = 0;
        plan_key(K_DIG, 1, 3, 0);
        while (plan.size() > 5) void'(plan.pop_back());
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp) begin
                errors++;
                $display("[TB] FAIL reset_pre cycle %0d outputs got %h want %h", cyc, out_vec, e.exp);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b0; alu_done = 1'b1; key_valid = 1'b0;
        #1;
        checks++;
        if (out_vec !== ev(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0) ||
            digit_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_add got %h/%0d want key_ready only/0", out_vec, digit_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; alu_done = 1'b0;
        model_count = 0; model_err = 1'b0;
        plan_key(K_DIG, 1, 1, 0);
        idle_cycles(1);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL reset_post cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_digit();
        noise = 0;
        plan_key(K_CLR, 1, 1, 0);
        plan_key(K_DIG, 1, 1, 0);
        idle_cycles(1);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL digit cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_digit_limit();
        noise = 0;
        plan_key(K_CLR, 1, 1, 0);
        for (int i = 0; i < MAX_DIGITS + 1; i++) plan_key(K_DIG, 1, 1, 0);
        idle_cycles(2);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL digit_limit cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_operator_equals();
        noise = 0;
        plan_key(K_OP, 5, 1, 0);
        idle_cycles(1);
        plan_key(K_EQ, 5, 1, 0);
        idle_cycles(1);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL op_equals cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_error();
        noise = 0;
        plan_key(K_OP, 3, 1, 1);
        idle_cycles(1);
        plan_key(K_DIG, 1, 1, 0);
        plan_key(K_EQ, 1, 1, 0);
        plan_key(K_CLR, 1, 1, 0);
        idle_cycles(2);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL alu_error cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_drop();
        noise = 2;
        plan_key(K_DIG, 3, 2, 0);
        plan_key(K_OP, 4, 1, 0);
        plan_key(K_CLR, 1, 1, 0);
        noise = 0;
        idle_cycles(1);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL busy_drop cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int r;
        logic [1:0] kt;
        noise = 1;
        for (int k = 0; k < 80; k++) begin
            r  = $urandom_range(0, 9);
            kt = (r <= 5) ? K_DIG : (r <= 7) ? K_OP : (r == 8) ? K_EQ : K_CLR;
            plan_key(kt, $urandom_range(1, 4), $urandom_range(1, 4),
                     ($urandom_range(0, 11) == 0) ? $urandom_range(1, 2) : 0);
            idle_cycles($urandom_range(0, 2));
        end
        noise = 0;
        idle_cycles(1);
        cyc = 0;
        while (plan.size() != 0) begin
            e = plan.pop_front(); drive(e); cyc++;
            checks++;
            if (out_vec !== e.exp || digit_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got %h/%0d want %h/%0d",
                         cyc, out_vec, digit_count, e.exp, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_digit_limit();
        test_operator_equals();
        test_alu_error();
        test_busy_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
